// File: rtl/tdm_pkg.sv
// Shared definitions for the 4:1 TDM link (mux and demux sides).
// Slot indices, frame geometry and the receive FSM state encoding.
package tdm_pkg;

    // Slot positions within one frame; slot A always carries frame_start.
    localparam logic [1:0] SLOT_A = 2'd0;
    localparam logic [1:0] SLOT_B = 2'd1;
    localparam logic [1:0] SLOT_C = 2'd2;
    localparam logic [1:0] SLOT_D = 2'd3;

    // Number of slots per frame.
    localparam int NSLOT = 4;

    // Framing FSM: HUNT waits for frame_start, SYNC tracks slots.
    typedef enum logic {
        ST_HUNT = 1'b0,
        ST_SYNC = 1'b1
    } state_t;

    // Next slot index with wrap after the last slot of the frame.
    function automatic logic [1:0] slot_next(input logic [1:0] slot);
        return (slot == SLOT_D) ? SLOT_A : slot + 2'd1;
    endfunction

endpackage : tdm_pkg

// File: rtl/tdm_slot_counter.sv
// Slot index tracker for the TDM receiver.
// Holds the index of the next expected sample; clear has priority over
// load_one, which has priority over advance. With no command it holds,
// which is how gaps in din_valid are absorbed.
module tdm_slot_counter
    import tdm_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       load_one,
    input  logic       advance,
    output logic [1:0] slot,
    output logic       s0,
    output logic       s1
);

    logic [1:0] slot_q;

    // Slot register: clear, restart after slot A, or step with wrap.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking (<=) so every register
        // samples pre-edge values, independent of statement order.
        if (rst) begin
            slot_q <= SLOT_A;
        end else if (clear) begin
            slot_q <= SLOT_A;
        end else if (load_one) begin
            slot_q <= SLOT_B;
        end else if (advance) begin
            slot_q <= slot_next(slot_q);
        end
    end

    assign slot = slot_q;
    assign s0   = slot_q[0];
    assign s1   = slot_q[1];

endmodule : tdm_slot_counter

// File: rtl/tdm_demux4.sv
// Receive end of the 4:1 TDM link.
// Collects one sample per slot into shadow registers and publishes all
// four channels together one cycle after the slot-D sample is accepted.
// A framing FSM hunts for frame_start, then checks that frame_start keeps
// arriving exactly at slot A; violations pulse sync_err.
module tdm_demux4
    import tdm_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic             frame_start,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] d,
    output logic             frame_valid,
    output logic             s0,
    output logic             s1,
    output logic             locked,
    output logic             sync_err
);

    state_t           state;
    state_t           state_next;
    logic             accept;
    logic [1:0]       slot;

    // Slot counter commands.
    logic             cnt_clear;
    logic             cnt_load;
    logic             cnt_adv;

    // Shadow write control; shadow_idx selects which slot register is written.
    logic             shadow_we;
    logic [1:0]       shadow_idx;
    logic             publish;
    logic             err_set;

    // Shadow registers for slots A..C; slot D is taken straight from din
    // at publish time, so it needs no storage.
    logic [WIDTH-1:0] shadow_a;
    logic [WIDTH-1:0] shadow_b;
    logic [WIDTH-1:0] shadow_c;

    assign accept = din_valid & ~rst;

    tdm_slot_counter u_slot_counter (
        .clk      (clk),
        .rst      (rst),
        .clear    (cnt_clear),
        .load_one (cnt_load),
        .advance  (cnt_adv),
        .slot     (slot),
        .s0       (s0),
        .s1       (s1)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_HUNT;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and per-sample decisions: where to store, when to publish,
    // when to flag a framing error.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_next = state;
        cnt_clear  = 1'b0;
        cnt_load   = 1'b0;
        cnt_adv    = 1'b0;
        shadow_we  = 1'b0;
        shadow_idx = slot;
        publish    = 1'b0;
        err_set    = 1'b0;

        unique case (state)
            ST_HUNT: begin
                // Samples before the first frame_start are dropped.
                if (accept && frame_start) begin
                    shadow_we  = 1'b1;
                    shadow_idx = SLOT_A;
                    cnt_load   = 1'b1;
                    state_next = ST_SYNC;
                end
            end

            ST_SYNC: begin
                if (accept) begin
                    if (frame_start && (slot != SLOT_A)) begin
                        // Early frame_start: drop the partial frame and
                        // restart alignment on this sample.
                        err_set    = 1'b1;
                        shadow_we  = 1'b1;
                        shadow_idx = SLOT_A;
                        cnt_load   = 1'b1;
                    end else if (!frame_start && (slot == SLOT_A)) begin
                        // Missing frame_start: alignment lost, sample dropped.
                        err_set    = 1'b1;
                        cnt_clear  = 1'b1;
                        state_next = ST_HUNT;
                    end else begin
                        // In-frame sample; slot D completes the frame.
                        shadow_we = (slot != SLOT_D);
                        publish   = (slot == SLOT_D);
                        cnt_adv   = 1'b1;
                    end
                end
            end

            default: begin
                state_next = ST_HUNT;
                cnt_clear  = 1'b1;
            end
        endcase
    end

    // Shadow capture for slots A..C; holds across din_valid gaps.
    always_ff @(posedge clk) begin
        // NOTE: these few registers are reset because reset must discard any
        // partial frame; a large sample RAM would normally be left unreset.
        if (rst) begin
            shadow_a <= '0;
            shadow_b <= '0;
            shadow_c <= '0;
        end else if (shadow_we) begin
            unique case (shadow_idx)
                SLOT_A:  shadow_a <= din;
                SLOT_B:  shadow_b <= din;
                SLOT_C:  shadow_c <= din;
                default: ;
            endcase
        end
    end

    // Output channels: all four update together on a completed frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            a <= '0;
            b <= '0;
            c <= '0;
            d <= '0;
        end else if (publish) begin
            a <= shadow_a;
            b <= shadow_b;
            c <= shadow_c;
            d <= din;
        end
    end

    // Single-cycle status pulses, one cycle after the triggering accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
        end else begin
            frame_valid <= publish;
            sync_err    <= err_set;
        end
    end

    assign locked = (state == ST_SYNC);

endmodule : tdm_demux4

// File: tb/tb_tdm_demux4.sv
// Self-checking bench for tdm_demux4 (WIDTH=1).
// A behavioural model tracks the framing; completed frames are pushed to a
// scoreboard queue when their last sample is driven and popped when the DUT
// raises frame_valid.
module tb_tdm_demux4;

    localparam int W = 1;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] din;
    logic         din_valid;
    logic         frame_start;
    logic [W-1:0] a, b, c, d;
    logic         frame_valid, s0, s1, locked, sync_err;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state.
    logic         m_sync;
    logic [1:0]   m_slot;
    logic [W-1:0] m_sh [3];
    logic [3:0]   m_out;
    logic         exp_fv, exp_err;
    logic [3:0]   sb_q [$];

    tdm_demux4 #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .din         (din),
        .din_valid   (din_valid),
        .frame_start (frame_start),
        .a           (a),
        .b           (b),
        .c           (c),
        .d           (d),
        .frame_valid (frame_valid),
        .s0          (s0),
        .s1          (s1),
        .locked      (locked),
        .sync_err    (sync_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance the model for one cycle of stimulus.
    task automatic model(input logic r, input logic dv, input logic [W-1:0] dd, input logic fs);
        exp_fv  = 1'b0;
        exp_err = 1'b0;
        if (r) begin
            m_sync = 1'b0;
            m_slot = 2'd0;
            for (int i = 0; i < 3; i++) m_sh[i] = '0;
            m_out  = 4'h0;
        end else if (dv) begin
            if (!m_sync) begin
                if (fs) begin
                    m_sh[0] = dd;
                    m_slot  = 2'd1;
                    m_sync  = 1'b1;
                end
            end else if (fs && m_slot != 2'd0) begin
                exp_err = 1'b1;
                m_sh[0] = dd;
                m_slot  = 2'd1;
            end else if (!fs && m_slot == 2'd0) begin
                exp_err = 1'b1;
                m_sync  = 1'b0;
                m_slot  = 2'd0;
            end else if (m_slot == 2'd3) begin
                m_out  = {m_sh[0], m_sh[1], m_sh[2], dd};
                sb_q.push_back(m_out);
                exp_fv = 1'b1;
                m_slot = 2'd0;
            end else begin
                m_sh[m_slot] = dd;
                m_slot       = m_slot + 2'd1;
            end
        end
    endtask

    // Drive one cycle, then compare all outputs 1 time unit after the edge.
    task automatic step(input logic dv, input logic [W-1:0] dd, input logic fs,
                        input logic r = 1'b0);
        model(r, dv, dd, fs);
        rst         = r;
        din_valid   = dv;
        din         = dd;
        frame_start = fs;
        @(posedge clk);
        #1;
        check("frame_valid", frame_valid, exp_fv);
        check("sync_err", sync_err, exp_err);
        check("locked", locked, m_sync);
        check("slot", {s1, s0}, m_slot);
        check("channels", {a, b, c, d}, m_out);
        if (frame_valid) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_frame", 1, 0);
            end else begin
                check("sb_frame", {a, b, c, d}, sb_q.pop_front());
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0);
    endtask

    task automatic frame(input logic [3:0] bits);
        for (int i = 0; i < 4; i++) step(1'b1, bits[3-i], (i == 0));
    endtask

    initial begin
        rst = 1'b1; din = '0; din_valid = 1'b0; frame_start = 1'b0;

        // Reset state.
        step(1'b0, '0, 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b1);
        check("reset_outs", {a, b, c, d, frame_valid, sync_err, locked, s1, s0}, 0);

        // Samples before frame_start are dropped.
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        check("hunt_drop", {a, b, c, d, locked}, 0);

        // Basic frame 1,0,1,1.
        frame(4'b1011);
        check("t1_abcd", {a, b, c, d}, 4'b1011);
        check("t1_fv", frame_valid, 1);
        check("t1_lock_slot", {locked, s1, s0}, 3'b100);
        idle(1);
        check("t1_fv_pulse", frame_valid, 0);

        // Frame with gaps 0..3 before each slot; also frame_start without din_valid.
        for (int i = 0; i < 4; i++) begin
            for (int g = 0; g < i; g++) step(1'b0, 1'b1, (g == 0));
            step(1'b1, (i == 1 || i == 2) ? 1'b1 : 1'b0, (i == 0));
        end
        check("t3_abcd", {a, b, c, d}, 4'b0110);
        idle(3);
        check("t3_held", {a, b, c, d, frame_valid}, 5'b01100);

        // Early frame_start discards the partial frame.
        frame(4'b1111);
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        check("t4_err", sync_err, 1);
        check("t4_no_publish", {a, b, c, d, frame_valid}, 5'b11110);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        check("t4_abcd", {a, b, c, d, locked}, 5'b00001);

        // Missing frame_start at slot 0 drops lock; then reacquire.
        step(1'b1, 1'b1, 1'b0);
        check("t5_err_unlock", {sync_err, locked, s1, s0}, 4'b1000);
        frame(4'b1001);
        check("t5_reacq", {a, b, c, d, locked}, 5'b10011);

        // Reset mid-frame, then frame_start without din_valid.
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        check("t6_reset", {a, b, c, d, frame_valid, sync_err, locked, s1, s0}, 0);
        step(1'b0, 1'b1, 1'b1);
        check("t6_ignored", {locked, s1, s0}, 0);

        // Random traffic with occasional misplaced frame_start.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 3) != 0), 1'($urandom),
                 (m_slot == 2'd0) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 15) == 0));
        end
        idle(2);
        check("sb_drained", sb_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_tdm_demux4
